// File: rtl/ad_fifo_pkg.sv
// Shared types and default sizing for the USB2 receive add/drop elastic FIFO
// and its sequencing controller.
package ad_fifo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        TRACK,
        COOL,
        RECOVER
    } state_t;

    localparam int DEF_DEPTH     = 8;
    localparam int DEF_CNT_W     = 4;
    localparam int DEF_HI_THR    = 6;
    localparam int DEF_LO_THR    = 2;
    localparam int DEF_COOLDOWN  = 16;
    localparam int DEF_FLUSH_CYC = 4;

endpackage

// File: rtl/ad_fifo_ctrl_occ_counter.sv
// Saturating up/down counter (range 0..MAX) with synchronous clear and load.
// Serves as the occupancy model and as the cooldown/flush down-counter.
module occ_counter #(
    parameter int W   = 4,
    parameter int MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [W-1:0]      load_val,
    input  logic signed [2:0] delta,
    output logic [W-1:0]      value
);

    localparam logic signed [W+1:0] MAX_S = (W+2)'(MAX);

    logic signed [W+1:0] sum;

    // Two guard bits keep the sum exact for delta in -2..+2 before clamping.
    always_comb sum = $signed({2'b00, value}) + (W+2)'(delta);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            value <= '0;
        else if (clr)
            value <= '0;
        else if (load)
            value <= load_val;
        else if (sum[W+1])
            value <= '0;
        else if (sum > MAX_S)
            value <= W'(MAX);
        else
            value <= sum[W-1:0];
    end

endmodule

// File: rtl/ad_fifo_ctrl.sv
// Add/drop elastic FIFO sequencing controller: occupancy model, fill/track
// with windowed corrections, and flush/refill recovery on FIFO errors.
module ad_fifo_ctrl
    import ad_fifo_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int HI_THR    = DEF_HI_THR,
    parameter int LO_THR    = DEF_LO_THR,
    parameter int COOLDOWN  = DEF_COOLDOWN,
    parameter int FLUSH_CYC = DEF_FLUSH_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             wr_tick,
    input  logic             rd_tick,
    input  logic             adj_ok,
    input  logic             underflow,
    input  logic             overflow,
    output logic             rd_en,
    output logic             add,
    output logic             drop,
    output logic             flush,
    output logic [CNT_W-1:0] level,
    output logic             locked,
    output logic [7:0]       err_count
);

    localparam int TMR_MAX = (COOLDOWN > FLUSH_CYC ? COOLDOWN : FLUSH_CYC) - 1;
    localparam int TMR_W   = (TMR_MAX > 0) ? $clog2(TMR_MAX + 1) : 1;

    state_t             state, nxt;
    logic [TMR_W-1:0]   tmr, tmr_val;
    logic               tmr_load;
    logic               add_n, drop_n;
    logic               fifo_err;
    logic               wr_cnt, rd_cnt;
    logic               lvl_clr;
    logic signed [2:0]  lvl_delta;

    assign fifo_err = underflow | overflow;

    always_comb begin
        nxt      = state;
        add_n    = 1'b0;
        drop_n   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (!enable) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE:    nxt = FILL;
                FILL:    if (level >= CNT_W'(DEPTH / 2)) nxt = TRACK;
                TRACK: begin
                    if (fifo_err) begin
                        nxt = RECOVER;
                    end else if (adj_ok && level >= CNT_W'(HI_THR)) begin
                        nxt    = COOL;
                        drop_n = 1'b1;
                    end else if (adj_ok && level <= CNT_W'(LO_THR)) begin
                        nxt   = COOL;
                        add_n = 1'b1;
                    end
                end
                COOL: begin
                    if (fifo_err)       nxt = RECOVER;
                    else if (tmr == '0) nxt = TRACK;
                end
                RECOVER: if (tmr == '0) nxt = FILL;
                default: nxt = IDLE;
            endcase
        end
        // Timer holds remaining-cycles-minus-one so the exit test is tmr == 0.
        if (nxt == COOL && state != COOL) begin
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(COOLDOWN - 1);
        end else if (nxt == RECOVER && state != RECOVER) begin
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(FLUSH_CYC - 1);
        end
    end

    // Corrections apply in the cycle the registered Add/Drop pulse is visible.
    always_comb begin
        wr_cnt    = wr_tick && state != IDLE && state != RECOVER;
        rd_cnt    = rd_tick && rd_en;
        lvl_delta = $signed({2'b00, wr_cnt}) - $signed({2'b00, rd_cnt})
                  + $signed({2'b00, add})    - $signed({2'b00, drop});
        lvl_clr   = nxt == IDLE || nxt == RECOVER;
    end

    occ_counter #(.W(CNT_W), .MAX(DEPTH)) u_level (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (lvl_clr),
        .load     (1'b0),
        .load_val ('0),
        .delta    (lvl_delta),
        .value    (level)
    );

    occ_counter #(.W(TMR_W), .MAX(TMR_MAX)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (1'b0),
        .load     (tmr_load),
        .load_val (tmr_val),
        .delta    (3'sb111),
        .value    (tmr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_en     <= 1'b0;
            locked    <= 1'b0;
            add       <= 1'b0;
            drop      <= 1'b0;
            flush     <= 1'b0;
            err_count <= '0;
        end else begin
            state  <= nxt;
            rd_en  <= nxt == TRACK || nxt == COOL;
            locked <= nxt == TRACK || nxt == COOL;
            add    <= add_n;
            drop   <= drop_n;
            flush  <= nxt == RECOVER;
            if (nxt == RECOVER && state != RECOVER && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_ad_fifo_ctrl.sv
// Self-checking bench for ad_fifo_ctrl: directed scenarios plus randomized
// traffic compared cycle-by-cycle against a rule-level reference model.
module tb_ad_fifo_ctrl;

    localparam int DEPTH = 8, CNT_W = 4, HI = 6, LO = 2, COOL_N = 16, FLUSH_N = 4;
    localparam int S_IDLE = 0, S_FILL = 1, S_TRACK = 2, S_COOL = 3, S_REC = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic enable = 1'b0, wr_tick = 1'b0, rd_tick = 1'b0, adj_ok = 1'b0;
    logic underflow = 1'b0, overflow = 1'b0;
    logic rd_en, add, drop, flush, locked;
    logic [CNT_W-1:0] level;
    logic [7:0] err_count;

    int vectors = 0, miscompares = 0;

    // Reference model: phase, cycles left in a timed phase, occupancy, errors.
    int m_st, m_left, m_level, m_err;
    bit m_rden, m_add, m_drop, m_flush, m_locked;

    always #5 clk = ~clk;

    ad_fifo_ctrl #(
        .DEPTH(DEPTH), .CNT_W(CNT_W), .HI_THR(HI), .LO_THR(LO),
        .COOLDOWN(COOL_N), .FLUSH_CYC(FLUSH_N)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr_tick(wr_tick),
        .rd_tick(rd_tick), .adj_ok(adj_ok), .underflow(underflow),
        .overflow(overflow), .rd_en(rd_en), .add(add), .drop(drop),
        .flush(flush), .level(level), .locked(locked), .err_count(err_count)
    );

    function automatic logic [16:0] dut_vec();
        return {rd_en, add, drop, flush, locked, level, err_count};
    endfunction

    function automatic logic [16:0] exp_vec();
        return {m_rden, m_add, m_drop, m_flush, m_locked, 4'(m_level), 8'(m_err)};
    endfunction

    function automatic void model_reset();
        m_st = S_IDLE; m_left = 0; m_level = 0; m_err = 0;
        m_rden = 0; m_add = 0; m_drop = 0; m_flush = 0; m_locked = 0;
    endfunction

    function automatic void model_step(bit en, bit wr, bit rd, bit adj, bit uf, bit ov);
        int lvl, ns;
        bit a, d;
        lvl = m_level + int'(wr && m_st != S_IDLE && m_st != S_REC)
            - int'(rd && m_rden) + int'(m_add) - int'(m_drop);
        if (lvl < 0) lvl = 0;
        if (lvl > DEPTH) lvl = DEPTH;
        a = 0; d = 0; ns = m_st;
        if (!en) ns = S_IDLE;
        else case (m_st)
            S_IDLE:  ns = S_FILL;
            S_FILL:  if (m_level >= DEPTH / 2) ns = S_TRACK;
            S_TRACK: begin
                if (uf || ov) ns = S_REC;
                else if (adj && m_level >= HI) begin ns = S_COOL; d = 1; m_left = COOL_N; end
                else if (adj && m_level <= LO) begin ns = S_COOL; a = 1; m_left = COOL_N; end
            end
            S_COOL: begin
                if (uf || ov) ns = S_REC;
                else begin m_left--; if (m_left == 0) ns = S_TRACK; end
            end
            S_REC: begin m_left--; if (m_left == 0) ns = S_FILL; end
            default: ns = S_IDLE;
        endcase
        if (ns == S_REC && m_st != S_REC) begin
            m_left = FLUSH_N;
            if (m_err < 255) m_err++;
        end
        if (ns == S_IDLE || ns == S_REC) lvl = 0;
        m_st = ns; m_level = lvl; m_add = a; m_drop = d;
        m_rden = (ns == S_TRACK || ns == S_COOL);
        m_locked = m_rden;
        m_flush = (ns == S_REC);
    endfunction

    task automatic cycle(bit en, bit wr, bit rd, bit adj, bit uf, bit ov);
        enable = en; wr_tick = wr; rd_tick = rd; adj_ok = adj;
        underflow = uf; overflow = ov;
        @(posedge clk);
        model_step(en, wr, rd, adj, uf, ov);
        #1;
    endtask

    task automatic goto_cool(string tag);
        int n = 0;
        while (m_st != S_COOL && n < 60) begin
            cycle(1, 1, 0, 1, 0, 0);
            n++;
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL %s_approach got %h want %h", tag, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (m_st != S_COOL) begin
            miscompares++;
            $display("FAIL %s_reach_cool got timeout want cool within 60 cycles", tag);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (dut_vec() !== 17'h0) begin
                miscompares++;
                $display("FAIL reset[%0d] got %h want %h", i, dut_vec(), 17'h0);
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            cycle(1, 1, 0, 0, 0, 0);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL fill[%0d] got %h want %h", i, dut_vec(), exp_vec());
            end
            vectors++;
            if (locked !== (i >= 5) || rd_en !== (i >= 5)) begin
                miscompares++;
                $display("FAIL fill_lock[%0d] got %b%b want %b", i, locked, rd_en, i >= 5);
            end
            if (i == 4) begin
                vectors++;
                if (level !== 4'd4) begin
                    miscompares++;
                    $display("FAIL fill_level4 got %0d want 4", level);
                end
            end
        end
    endtask

    task automatic test_drop();
        int last = -100, ndrop = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1, 1, i[0], 1, 0, 0);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL drop[%0d] got %h want %h", i, dut_vec(), exp_vec());
            end
            if (drop) begin
                ndrop++;
                vectors++;
                if (i - last < COOL_N + 1) begin
                    miscompares++;
                    $display("FAIL drop_spacing got %0d want >= %0d", i - last, COOL_N + 1);
                end
                last = i;
            end
            vectors++;
            if (add) begin
                miscompares++;
                $display("FAIL drop_no_add got add=1 want add=0 at %0d", i);
            end
        end
        vectors++;
        if (ndrop < 1) begin
            miscompares++;
            $display("FAIL drop_seen got %0d want >= 1", ndrop);
        end
    endtask

    task automatic test_add();
        int nadd = 0;
        for (int i = 0; i < 50; i++) begin
            cycle(1, i[0], 1, m_level <= 1, 0, 0);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL add[%0d] got %h want %h", i, dut_vec(), exp_vec());
            end
            if (add) nadd++;
            vectors++;
            if (add && drop) begin
                miscompares++;
                $display("FAIL add_drop_excl got 11 want not both at %0d", i);
            end
        end
        vectors++;
        if (nadd < 1) begin
            miscompares++;
            $display("FAIL add_seen got %0d want >= 1", nadd);
        end
    endtask

    task automatic test_overflow_recover();
        int nflush = 0;
        int err0;
        goto_cool("ovf");
        err0 = int'(err_count);
        cycle(1, 1, 0, 0, 0, 1);
        vectors++;
        if (flush !== 1'b1 || level !== '0 || int'(err_count) !== err0 + 1) begin
            miscompares++;
            $display("FAIL ovf_entry got flush=%b level=%0d err=%0d want 1 0 %0d",
                     flush, level, err_count, err0 + 1);
        end
        nflush = 1;
        // Flags asserted during recovery must be ignored.
        for (int i = 0; i < 10; i++) begin
            cycle(1, 1, 0, 0, i < 3, i < 3);
            if (flush) nflush++;
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL ovf_seq[%0d] got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (nflush !== FLUSH_N) begin
            miscompares++;
            $display("FAIL ovf_flush_len got %0d want %0d", nflush, FLUSH_N);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom % 50) != 0, $urandom % 2, $urandom % 2,
                  ($urandom % 4) == 0, ($urandom % 40) == 0, ($urandom % 40) == 0);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random[%0d] got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_err_saturate();
        for (int i = 0; i < 3100; i++) begin
            cycle(1, 1, 0, 0, 1, 0);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL errsat[%0d] got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (err_count !== 8'd255) begin
            miscompares++;
            $display("FAIL errsat_final got %0d want 255", err_count);
        end
    endtask

    task automatic test_enable_drop();
        goto_cool("endrop");
        cycle(0, 1, 1, 1, 0, 0);
        vectors++;
        if ({rd_en, add, drop, flush, locked, level} !== 9'h0 || err_count !== 8'(m_err)) begin
            miscompares++;
            $display("FAIL endrop_outputs got %h want %h", dut_vec(), exp_vec());
        end
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, 1, 1, 1, 1);
            vectors++;
            if (dut_vec() !== exp_vec() || add || drop) begin
                miscompares++;
                $display("FAIL endrop_idle[%0d] got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        goto_cool("rstmid");
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (dut_vec() !== 17'h0) begin
            miscompares++;
            $display("FAIL rstmid_async got %h want %h", dut_vec(), 17'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle(1, 1, 0, 1, 0, 0);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL rstmid_after[%0d] got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drop();
        test_add();
        test_overflow_recover();
        test_random();
        test_enable_drop();
        test_err_saturate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
